// File: rtl/sdram_fill_pkg.sv
// Shared types and default widths for the SDRAM fill engine and the capture top.
package sdram_fill_pkg;

  localparam int DEF_DATA_W  = 256;
  localparam int DEF_ADDR_W  = 27;
  localparam int DEF_BURST_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } fill_state_e;

endpackage

// File: rtl/sdram_fill_engine_if.sv
// Avalon-MM write-burst bus between the fill engine (master) and the SDRAM controller (slave).
interface sdram_fill_engine_if #(
  parameter int DATA_W  = sdram_fill_pkg::DEF_DATA_W,
  parameter int ADDR_W  = sdram_fill_pkg::DEF_ADDR_W,
  parameter int BURST_W = sdram_fill_pkg::DEF_BURST_W
);
  logic [ADDR_W-1:0]   sdram_address;
  logic [BURST_W-1:0]  sdram_burstcount;
  logic                sdram_waitrequest;
  logic                sdram_write;
  logic                sdram_read;
  logic [DATA_W-1:0]   sdram_writedata;
  logic [DATA_W/8-1:0] sdram_byteenable;

  modport master (
    output sdram_address, sdram_burstcount, sdram_write, sdram_read,
           sdram_writedata, sdram_byteenable,
    input  sdram_waitrequest
  );

  modport slave (
    input  sdram_address, sdram_burstcount, sdram_write, sdram_read,
           sdram_writedata, sdram_byteenable,
    output sdram_waitrequest
  );
endinterface

// File: rtl/sdram_fill_burst_len.sv
// Combinational burst sizing: launch-time clamp of the requested length,
// clip of the next burst at the window end, and the flush length.
module sdram_fill_burst_len #(
  parameter int ADDR_W    = 27,
  parameter int BURST_W   = 8,
  parameter int LEVEL_W   = 10,
  parameter int MAX_BURST = 16
) (
  input  logic [BURST_W-1:0] req_burst,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [ADDR_W-1:0]  end_addr,
  input  logic [LEVEL_W-1:0] level,
  output logic [BURST_W-1:0] clamped,
  output logic [BURST_W-1:0] len,
  output logic               level_ok,
  output logic [BURST_W-1:0] flush_len,
  output logic               level_nz
);
  // Common compare width wide enough for level, window span and burst length.
  localparam int AW1 = ADDR_W + 1;
  localparam int CW0 = (LEVEL_W > AW1) ? LEVEL_W : AW1;
  localparam int CW  = (BURST_W > CW0) ? BURST_W : CW0;

  logic [CW-1:0] remain;
  logic [CW-1:0] len_w;

  // Requested length forced into 1..MAX_BURST.
  always_comb begin
    if (req_burst == '0)
      clamped = BURST_W'(1);
    else if (req_burst > BURST_W'(MAX_BURST))
      clamped = BURST_W'(MAX_BURST);
    else
      clamped = req_burst;
  end

  // Beats left in the window bound the burst; a flush takes whatever is upstream,
  // which is always shorter than len when it is used.
  always_comb begin
    remain    = CW'(end_addr) - CW'(addr) + CW'(1);
    len_w     = (remain < CW'(cfg_burst)) ? remain : CW'(cfg_burst);
    len       = BURST_W'(len_w);
    level_ok  = CW'(level) >= len_w;
    flush_len = BURST_W'(level);
    level_nz  = |level;
  end
endmodule

// File: rtl/sdram_fill_engine.sv
// SDRAM write-fill engine: drains a show-ahead stream into an address window
// with Avalon-MM burst writes. Optional circular fill: SDRAM_FILL_WRAP_EN.
module sdram_fill_engine
  import sdram_fill_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_W   = DEF_BURST_W,
  parameter int MAX_BURST = 16,
  parameter int LEVEL_W   = 10
) (
  input  logic               sdram_clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic [LEVEL_W-1:0] in_level,
  output logic               in_ready,
  input  logic               fill_launch,
  input  logic               fill_terminate,
  input  logic               fill_wrap,
  input  logic [ADDR_W-1:0]  fill_addr_start,
  input  logic [ADDR_W-1:0]  fill_addr_end,
  input  logic [BURST_W-1:0] fill_burst,
  output logic               fill_running,
  output logic               fill_done,
  output logic               fill_wrapped,
  output logic [ADDR_W-1:0]  fill_addr_last,
  sdram_fill_engine_if.master avm
);
  fill_state_e        state_q, state_d;
  logic               launch_q, terminate_q;
  logic [ADDR_W-1:0]  start_q, start_d, end_q, end_d, addr_q, addr_d;
  logic [ADDR_W-1:0]  address_q, address_d, last_q, last_d;
  logic [BURST_W-1:0] cfg_burst_q, cfg_burst_d, beats_q, beats_d, burstcount_q, burstcount_d;
  logic               write_q, write_d, done_q, done_d, running_q, running_d;
  logic               wrapped_q, wrapped_d, wrap_q, wrap_d;
  logic               wrap_en, accept;
  logic [BURST_W-1:0] clamped, len, flush_len;
  logic               level_ok, level_nz;
  logic               unused_inputs;

`ifdef SDRAM_FILL_WRAP_EN
  assign wrap_en = fill_wrap;
`else
  assign wrap_en = 1'b0;
`endif
  // The stream is trusted through in_level, so in_valid carries no extra information.
  assign unused_inputs = ^{in_valid, fill_wrap};

  sdram_fill_burst_len #(
    .ADDR_W(ADDR_W), .BURST_W(BURST_W), .LEVEL_W(LEVEL_W), .MAX_BURST(MAX_BURST)
  ) u_len (
    .req_burst(fill_burst), .cfg_burst(cfg_burst_q), .addr(addr_q), .end_addr(end_q),
    .level(in_level), .clamped(clamped), .len(len), .level_ok(level_ok),
    .flush_len(flush_len), .level_nz(level_nz)
  );

  assign accept = write_q & ~avm.sdram_waitrequest;

  // Next-state and registered-output computation for the IDLE/WAIT/BURST controller.
  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    end_d        = end_q;
    addr_d       = addr_q;
    address_d    = address_q;
    last_d       = last_q;
    cfg_burst_d  = cfg_burst_q;
    beats_d      = beats_q;
    burstcount_d = burstcount_q;
    write_d      = write_q;
    wrapped_d    = wrapped_q;
    wrap_d       = wrap_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch_q) begin
          start_d     = fill_addr_start;
          end_d       = fill_addr_end;
          addr_d      = fill_addr_start;
          cfg_burst_d = clamped;
          wrap_d      = wrap_en;
          wrapped_d   = 1'b0;
          if (fill_addr_end < fill_addr_start)
            done_d = 1'b1;
          else
            state_d = WAIT;
        end
      end
      WAIT: begin
        if (level_ok) begin
          state_d      = BURST;
          write_d      = 1'b1;
          address_d    = addr_q;
          burstcount_d = len;
          beats_d      = len;
        end else if (terminate_q && level_nz) begin
          state_d      = BURST;
          write_d      = 1'b1;
          address_d    = addr_q;
          burstcount_d = flush_len;
          beats_d      = flush_len;
        end else if (terminate_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      BURST: begin
        // addr_q walks with the beats so it already points past the burst at the end.
        if (accept) begin
          last_d  = addr_q;
          addr_d  = addr_q + ADDR_W'(1);
          beats_d = beats_q - BURST_W'(1);
          if (beats_q == BURST_W'(1)) begin
            write_d = 1'b0;
            if (addr_q == end_q) begin
              if (wrap_q) begin
                addr_d    = start_q;
                wrapped_d = 1'b1;
                state_d   = WAIT;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d != IDLE);
  end

  // All engine state; reset abandons any burst in progress immediately.
  always_ff @(posedge sdram_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      launch_q     <= 1'b0;
      terminate_q  <= 1'b0;
      start_q      <= '0;
      end_q        <= '0;
      addr_q       <= '0;
      address_q    <= '0;
      last_q       <= '0;
      cfg_burst_q  <= '0;
      beats_q      <= '0;
      burstcount_q <= '0;
      write_q      <= 1'b0;
      done_q       <= 1'b0;
      running_q    <= 1'b0;
      wrapped_q    <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      launch_q     <= fill_launch;
      terminate_q  <= fill_terminate;
      start_q      <= start_d;
      end_q        <= end_d;
      addr_q       <= addr_d;
      address_q    <= address_d;
      last_q       <= last_d;
      cfg_burst_q  <= cfg_burst_d;
      beats_q      <= beats_d;
      burstcount_q <= burstcount_d;
      write_q      <= write_d;
      done_q       <= done_d;
      running_q    <= running_d;
      wrapped_q    <= wrapped_d;
      wrap_q       <= wrap_d;
    end
  end

  assign in_ready             = accept;
  assign fill_running         = running_q;
  assign fill_done            = done_q;
  assign fill_wrapped         = wrapped_q;
  assign fill_addr_last       = last_q;
  assign avm.sdram_address    = address_q;
  assign avm.sdram_burstcount = burstcount_q;
  assign avm.sdram_write      = write_q;
  assign avm.sdram_read       = 1'b0;
  assign avm.sdram_writedata  = in_data;
  assign avm.sdram_byteenable = '1;
endmodule

// File: tb/tb_sdram_fill_engine.sv
// Directed table-driven bench for sdram_fill_engine plus reset/reject sequences.
module tb_sdram_fill_engine;
  localparam int DW = 32, AW = 12, BW = 8, LW = 10;

  logic          sdram_clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [LW-1:0] in_level = '0;
  logic          in_ready;
  logic          fill_launch = 1'b0, fill_terminate = 1'b0, fill_wrap = 1'b0;
  logic [AW-1:0] fill_addr_start = '0, fill_addr_end = '0;
  logic [BW-1:0] fill_burst = '0;
  logic          fill_running, fill_done, fill_wrapped;
  logic [AW-1:0] fill_addr_last;

  sdram_fill_engine_if #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) bus ();

  sdram_fill_engine #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .MAX_BURST(16), .LEVEL_W(LW)
  ) dut (
    .sdram_clk(sdram_clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_level(in_level), .in_ready(in_ready), .fill_launch(fill_launch),
    .fill_terminate(fill_terminate), .fill_wrap(fill_wrap),
    .fill_addr_start(fill_addr_start), .fill_addr_end(fill_addr_end),
    .fill_burst(fill_burst), .fill_running(fill_running), .fill_done(fill_done),
    .fill_wrapped(fill_wrapped), .fill_addr_last(fill_addr_last), .avm(bus)
  );

  always #5 sdram_clk = ~sdram_clk;

  typedef struct {
    int saddr, eaddr, burst, words;
    bit term, wrap, rnd, chk_last;
    int nb, fa, fbc, la, lbc, last;
    bit wrapped;
    int beats;
  } vec_t;

  int    n_vec = 0, n_err = 0;
  int    avail = 0, head = 0;
  bit    rnd_wait = 0;
  string ctx = "init";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0d, expected %0d", ctx, name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    in_level = (avail > 1023) ? 10'd1023 : LW'(avail);
    in_valid = (avail > 0);
    in_data  = DW'(head);
  endtask

  // One clock with FIFO pops applied after the edge; no observation.
  task automatic tick();
    logic acc;
    @(negedge sdram_clk);
    acc = in_ready;
    @(posedge sdram_clk); #1;
    if (acc) begin head++; avail--; end
    drive_fifo();
    bus.sdram_waitrequest = rnd_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
  endtask

  // Launch one fill and check bursts, data, latency and completion.
  task automatic run(input vec_t v, input int base);
    int nb = 0, beats = 0, readies = 0, done_cnt = 0, post = 0, lat = -1, cur_beats = 0;
    int exp_data, a, fa = 0, fbc = 0, la = 0, lbc = 0, cur_addr = 0, cur_bc = 0;
    logic prev_w = 1'b0, acc;
    avail = v.words; head = base; exp_data = base;
    rnd_wait = v.rnd;
    drive_fifo();
    fill_addr_start = AW'(v.saddr); fill_addr_end = AW'(v.eaddr);
    fill_burst = BW'(v.burst); fill_terminate = v.term; fill_wrap = v.wrap;
    fill_launch = 1'b1;
    for (int k = 0; k < 2000 && post < 3; k++) begin
      @(negedge sdram_clk);
      if (bus.sdram_write && !prev_w) begin
        nb++; cur_addr = int'(bus.sdram_address); cur_bc = int'(bus.sdram_burstcount); cur_beats = 0;
        if (nb == 1) begin fa = cur_addr; fbc = cur_bc; lat = k; end
        la = cur_addr; lbc = cur_bc;
      end else if (bus.sdram_write) begin
        check("addr_hold", 32'(bus.sdram_address), 32'(cur_addr));
        check("bc_hold", 32'(bus.sdram_burstcount), 32'(cur_bc));
        check("no_gap", (cur_beats < cur_bc) ? 32'd1 : 32'd0, 32'd1);
      end
      if (!bus.sdram_write && prev_w) check("burst_beats", 32'(cur_beats), 32'(cur_bc));
      if (in_ready) readies++;
      if (bus.sdram_write && !bus.sdram_waitrequest) begin
        check("data", bus.sdram_writedata, 32'(exp_data));
        exp_data++;
        a = cur_addr + cur_beats;
        check("in_window", (a >= v.saddr && a <= v.eaddr) ? 32'd1 : 32'd0, 32'd1);
        cur_beats++; beats++;
      end
      if (fill_done) done_cnt++;
      if (done_cnt > 0) post++;
      prev_w = bus.sdram_write;
      acc = in_ready;
      @(posedge sdram_clk); #1;
      if (k == 0) fill_launch = 1'b0;
      if (acc) begin head++; avail--; end
      drive_fifo();
      bus.sdram_waitrequest = rnd_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("n_bursts", 32'(nb), 32'(v.nb));
    if (v.nb > 0) begin
      check("launch_latency", 32'(lat), 32'd3);
      check("first_addr", 32'(fa), 32'(v.fa));
      check("first_bc", 32'(fbc), 32'(v.fbc));
      check("last_burst_addr", 32'(la), 32'(v.la));
      check("last_burst_bc", 32'(lbc), 32'(v.lbc));
    end
    check("beats", 32'(beats), 32'(v.beats));
    check("ready_count", 32'(readies), 32'(v.beats));
    check("fifo_left", 32'(avail), 32'(v.words - v.beats));
    if (v.chk_last) check("addr_last", 32'(fill_addr_last), 32'(v.last));
    check("wrapped", 32'(fill_wrapped), 32'(v.wrapped));
    check("running_end", 32'(fill_running), 32'd0);
    fill_terminate = 1'b0; fill_wrap = 1'b0; rnd_wait = 0;
    bus.sdram_waitrequest = 1'b0;
  endtask

  vec_t vecs[10];
  vec_t rv;

  initial begin
    int d, r, w;
    bus.sdram_waitrequest = 1'b0;
    //          sa   ea   bu   wd  te wr rn cl  nb  fa  fbc  la  lbc last wp beats
    vecs[0] = '{0,   63,  8,   64, 0, 0, 0, 1,  8,  0,  8,   56, 8,  63,  0, 64};
    vecs[1] = '{0,   9,   4,   10, 0, 0, 0, 1,  3,  0,  4,   8,  2,  9,   0, 10};
    vecs[2] = '{0,   63,  8,   5,  1, 0, 0, 1,  1,  0,  5,   0,  5,  4,   0, 5};
    vecs[3] = '{0,   63,  8,   0,  1, 0, 0, 0,  0,  0,  0,   0,  0,  0,   0, 0};
    vecs[4] = '{20,  23,  0,   4,  0, 0, 0, 1,  4,  20, 1,   23, 1,  23,  0, 4};
    vecs[5] = '{0,   39,  200, 40, 0, 0, 0, 1,  3,  0,  16,  32, 8,  39,  0, 40};
    vecs[6] = '{0,   31,  8,   32, 0, 0, 1, 1,  4,  0,  8,   24, 8,  31,  0, 32};
    vecs[7] = '{0,   63,  8,   13, 1, 0, 0, 1,  2,  0,  8,   8,  5,  12,  0, 13};
    vecs[8] = '{5,   14,  4,   10, 0, 0, 0, 1,  3,  5,  4,   13, 2,  14,  0, 10};
`ifdef SDRAM_FILL_WRAP_EN
    vecs[9] = '{100, 115, 4,   40, 1, 1, 0, 1,  10, 100, 4,  104, 4, 107, 1, 40};
`else
    vecs[9] = '{100, 115, 4,   40, 1, 1, 0, 1,  4,  100, 4,  112, 4, 115, 0, 16};
`endif

    // Reset state, checked while reset is still asserted.
    repeat (2) @(posedge sdram_clk);
    #1;
    ctx = "reset";
    check("write", 32'(bus.sdram_write), 32'd0);
    check("read", 32'(bus.sdram_read), 32'd0);
    check("address", 32'(bus.sdram_address), 32'd0);
    check("burstcount", 32'(bus.sdram_burstcount), 32'd0);
    check("byteenable", 32'(bus.sdram_byteenable), 32'hF);
    check("running", 32'(fill_running), 32'd0);
    check("done", 32'(fill_done), 32'd0);
    check("wrapped", 32'(fill_wrapped), 32'd0);
    check("addr_last", 32'(fill_addr_last), 32'd0);
    check("in_ready", 32'(in_ready), 32'd0);
    @(negedge sdram_clk) rst = 1'b0;
    @(posedge sdram_clk); #1;

    for (int i = 0; i < 10; i++) begin
      ctx = $sformatf("vec%0d", i);
      run(vecs[i], 1000 * (i + 1));
      $display("vec%0d window %0d..%0d burst %0d words %0d: %0d checks so far, %0d bad",
               i, vecs[i].saddr, vecs[i].eaddr, vecs[i].burst, vecs[i].words, n_vec, n_err);
    end

    // Rejected launch: end below start.
    ctx = "reject";
    fill_addr_start = 12'd10; fill_addr_end = 12'd5; fill_burst = 8'd4;
    avail = 20; head = 50000; drive_fifo();
    fill_launch = 1'b1;
    d = 0; r = 0; w = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge sdram_clk);
      if (fill_done) d++;
      if (fill_running) r++;
      if (bus.sdram_write) w++;
      @(posedge sdram_clk); #1;
      fill_launch = 1'b0;
    end
    check("done_pulses", 32'(d), 32'd1);
    check("running_cycles", 32'(r), 32'd0);
    check("write_cycles", 32'(w), 32'd0);
    $display("reject: %0d checks so far, %0d bad", n_vec, n_err);

    // Reset mid-burst, then a clean relaunch.
    ctx = "midrst";
    fill_addr_start = 12'd0; fill_addr_end = 12'd63; fill_burst = 8'd8;
    avail = 64; head = 60000; drive_fifo();
    fill_launch = 1'b1;
    tick();
    fill_launch = 1'b0;
    repeat (4) tick();
    check("write_before_rst", 32'(bus.sdram_write), 32'd1);
    rst = 1'b1;
    #1;
    check("write_in_rst", 32'(bus.sdram_write), 32'd0);
    check("running_in_rst", 32'(fill_running), 32'd0);
    check("ready_in_rst", 32'(in_ready), 32'd0);
    @(negedge sdram_clk);
    @(negedge sdram_clk) rst = 1'b0;
    @(posedge sdram_clk); #1;
    rv = '{40, 47, 8, 8, 0, 0, 0, 1, 1, 40, 8, 40, 8, 47, 0, 8};
    run(rv, 70000);
    $display("midrst: %0d checks so far, %0d bad", n_vec, n_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sdram_fill_engine.md
# sdram_fill_engine

Parametrised SDRAM write-fill engine: drains a show-ahead word stream (the capture FIFO read side, already in the SDRAM clock domain) into a bounded SDRAM address window using Avalon-MM burst writes. It adds three behaviours:
- configurable burst length, clipped at the window end;
- end-of-capture flush with a short final burst;
- optional circular (ring-buffer) fill for pre-trigger capture, with last-address reporting.

## Interface
Parameters:
- DATA_W, 256, data beat width; byteenable width is DATA_W/8
- ADDR_W, 27, word address width, one address per beat
- BURST_W, 8, width of burstcount and fill_burst
- MAX_BURST, 16, upper clamp on burst length
- LEVEL_W, 10, width of in_level

Ports:
- sdram_clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- in_data  in  DATA_W  head word of upstream FIFO
- in_valid  in  1  upstream non-empty
- in_level  in  LEVEL_W  words available upstream, including head
- in_ready  out  1  pop strobe; one word is consumed per cycle it is high
- fill_launch  in  1  start fill; level-sampled
- fill_terminate  in  1  flush remaining data, then stop
- fill_wrap  in  1  circular mode select, latched at launch
- fill_addr_start, fill_addr_end  in  ADDR_W  inclusive window
- fill_burst  in  BURST_W  requested burst length, latched at launch
- fill_running  out  1  engine not IDLE
- fill_done  out  1  one-cycle pulse on return to IDLE
- fill_wrapped  out  1  window wrapped at least once this fill
- fill_addr_last  out  ADDR_W  address of last committed beat
- sdram_address  out  ADDR_W
- sdram_burstcount  out  BURST_W
- sdram_waitrequest  in  1
- sdram_write  out  1
- sdram_read  out  1  constant 0
- sdram_writedata  out  DATA_W  equals in_data
- sdram_byteenable  out  DATA_W/8  all ones

## Operation
- fill_launch and fill_terminate pass through one register stage before use.
- IDLE:
  - On launch: latch start, end, wrap and burst length. Burst length is the clamp of fill_burst to 1..MAX_BURST; a value of 0 becomes 1.
  - Set addr to start, clear fill_wrapped, go to WAIT.
  - If end < start, the launch is rejected: fill_done pulses and fill_running stays 0.
- WAIT: compute len = min(cfg_burst, end - addr + 1), evaluated in ADDR_W+1 bits.
  - If in_level >= len: go to BURST with burstcount = len.
  - Else if terminate and in_level > 0: go to BURST with burstcount = in_level (flush burst).
  - Else if terminate and in_level == 0: go to IDLE and pulse fill_done.
- BURST:
  - sdram_write is high and sdram_address holds addr for the whole burst.
  - in_ready = !sdram_waitrequest; each accepted beat decrements the beat counter and updates fill_addr_last.
  - After the final beat, addr advances by len.
  - If the final beat hit end: in wrap mode, addr becomes start, fill_wrapped is set, and the engine returns to WAIT. Otherwise the engine goes to IDLE and pulses fill_done.
  - In all other cases the engine returns to WAIT.
- Terminate during a burst never aborts it; the flush is evaluated in the next WAIT.
- Launch while not IDLE is ignored.

## Timing
- Reset values: all outputs 0 except sdram_byteenable (all ones); state is IDLE. The reset takes effect immediately, mid-burst included; the burst is abandoned.
- Launch pin to first sdram_write: 3 cycles (sync register, IDLE to WAIT, WAIT to BURST).
- There is at least one non-write cycle between consecutive bursts (the WAIT cycle).
- A burst of len beats with no waitrequest lasts exactly len cycles.
- in_level is trusted at the decision cycle only. Upstream level cannot drop except through in_ready, so no underrun check is made during a burst.
- fill_done is high for exactly one cycle.

## Configuration
- SDRAM_FILL_WRAP_EN defined: circular mode as described.
- SDRAM_FILL_WRAP_EN undefined:
  - fill_wrap is ignored and fill_wrapped is tied to 0.
  - Reaching end always ends the fill.

## Structure
- Package sdram_fill_pkg holds:
  - the state enum (IDLE, WAIT, BURST);
  - default constants for DATA_W, ADDR_W and BURST_W, which are shared with the capture top.
- Sub-module sdram_fill_burst_len: combinational burst-length computation (clamp, end clip, flush length).

## Test plan
- Window 0..63, burst 8, in_level held ≥ 8, no waitrequest -> 8 bursts at addresses 0, 8, …, 56; fill_done pulses once; fill_addr_last = 63.
- Window 0..9, burst 4 -> bursts (0,4), (4,4), (8,2); no write beyond address 9.
- Burst 8, stream only 5 words, then terminate -> one flush burst with burstcount 5 at the start address, then IDLE.
- Random waitrequest -> address and burstcount stable through each burst; the in_ready count equals the beats written; data order is preserved.
- With SDRAM_FILL_WRAP_EN, window 100..115, burst 4, 40 words, then terminate -> addresses wrap 112 to 100; fill_wrapped = 1; fill_addr_last = 107.
- rst asserted mid-burst -> sdram_write is 0 in the same cycle; a following launch restarts cleanly at the start address.
